spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for spi_sck, spi_cs_n and spi_mosi; legal range is 2..3.
REQ-002 SHALL have parameter TX_IDLE, default 8'hFF: byte shifted out when no tx byte is pending.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, 50 MHz nominal.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low; the block is in reset while rst=0.
REQ-005 SHALL have port spi_sck, input, 1 bit: SPI clock from the master, asynchronous to clk.
REQ-006 SHALL have port spi_cs_n, input, 1 bit: chip select, active-low, asynchronous to clk.
REQ-007 SHALL have port spi_mosi, input, 1 bit: serial data from the master.
REQ-008 SHALL have port spi_miso, output, 1 bit: serial data to the master.
REQ-009 SHALL have port tx_data, input, 8 bits: next byte to transmit.
REQ-010 SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-011 SHALL have port tx_ready, output, 1 bit: the tx holding register is empty.
REQ-012 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-013 SHALL have port rx_valid, output, 1 bit: rx_data is unread.
REQ-014 SHALL have port rx_ack, input, 1 bit: consumer has read rx_data.

Function
REQ-015 SHALL operate in SPI mode 0 (CPOL=0, CPHA=0), MSB first, with 8-bit frames.
REQ-016 SHALL pass spi_sck, spi_cs_n and spi_mosi through SYNC_STAGES flops before use, and SHALL detect sck edges from the synchronized value and its previous sample.
REQ-017 SHALL function correctly for an spi_sck frequency up to clk/8; 6.25 MHz at 50 MHz is in range.
REQ-018 SHALL implement the states IDLE and SHIFT: IDLE->SHIFT on synchronized cs_n falling; SHIFT->IDLE on synchronized cs_n high, from any bit position.
REQ-019 On entry to SHIFT, SHALL load the tx shift register from the holding register if it is full (and empty the holding register), otherwise load TX_IDLE; SHALL then drive spi_miso with bit 7.
REQ-020 On each synchronized sck rising edge in SHIFT, SHALL shift spi_mosi into the rx shift register LSB and increment the 3-bit bit counter.
REQ-021 On each synchronized sck falling edge in SHIFT, SHALL shift the tx register left; after the 8th falling edge, SHALL reload it per REQ-019 so that back-to-back bytes need no cs_n toggle.
REQ-022 When the bit counter wraps 7->0 on a rising edge, SHALL copy the rx shift register to rx_data and set rx_valid on the next clk.
REQ-023 rx_valid SHALL stay high until rx_ack=1 is sampled; if rx_ack coincides with a new byte completing, the new byte SHALL win and rx_valid SHALL stay 1.
REQ-024 tx_ready SHALL equal "holding register empty"; on tx_valid&&tx_ready, the holding register SHALL capture tx_data in one cycle.
REQ-025 When a reload occurs in the same cycle as a tx_valid&&tx_ready handshake, the reload SHALL use the fresh tx_data.
REQ-026 spi_miso SHALL be 0 in IDLE; no tristate is used.
REQ-027 A cs_n deassert mid-byte SHALL discard the partial bits, clear the bit counter, and leave rx_valid, rx_data and the holding register unchanged.

Reset
REQ-028 While rst=0, SHALL drive state=IDLE, bit counter=0, rx_data=8'h00, rx_valid=0, tx_ready=1, spi_miso=0, holding register empty, and shift registers=0; synchronizers SHALL reset to sck=0 and cs_n=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh cs_n falling edge.

Configuration
REQ-030 With SPI_SLAVE_OVERRUN_EN defined, SHALL add output rx_overrun (1 bit, sticky), set when a byte completes while rx_valid=1 and rx_ack=0, and cleared only by reset or by input ovr_clr (1 bit).
REQ-031 Without SPI_SLAVE_OVERRUN_EN, rx_overrun and ovr_clr SHALL be absent, and overwrite SHALL be silent.

Structure
REQ-032 Package spi_pkg SHALL hold SPI_BYTE_W=8, SPI_BIT_CNT_W=3, and the state typedef spi_slv_state_t {IDLE, SHIFT}.
REQ-033 Sub-module spi_sync (parameterized-depth single-bit synchronizer with reset value) SHALL be instantiated three times.

Verification
REQ-034 Preload tx 8'hA5; master sends 8'h3C at clk/8 -> rx_data=8'h3C, rx_valid=1, and the master receives 8'hA5.
REQ-035 No tx pending; one byte 8'h00 sent -> the master receives 8'hFF and tx_ready stays 1.
REQ-036 Two back-to-back bytes 8'h12, 8'h34 with cs_n held low, tx 8'h56 supplied after the first reload -> second miso byte=8'h56, and rx_data ends at 8'h34.
REQ-037 cs_n raised after 5 bits -> rx_valid unchanged; next full byte 8'h81 is received intact.
REQ-038 Two bytes received without rx_ack -> rx_data=second byte, and rx_overrun=1 if SPI_SLAVE_OVERRUN_EN is defined; ovr_clr pulse -> rx_overrun=0.
REQ-039 rst=0 pulsed after 3 bits -> all outputs at reset values; the following full frame is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths and FSM state type for the SPI slave
package spi_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - single-bit multi-flop synchronizer with selectable reset value
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 byte slave; SPI_SLAVE_OVERRUN_EN adds a sticky rx_overrun flag
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] TX_IDLE     = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  input  logic                  ovr_clr
`else
  input  logic                  rx_ack
`endif
);

  logic sck_s, cs_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
  );

  spi_slv_state_t            state, state_next;
  logic                      sck_prev, cs_prev;
  logic                      armed;
  logic [1:0]                flush_cnt;
  logic [SPI_BIT_CNT_W-1:0]  bit_cnt;
  logic [SPI_BYTE_W-1:0]     rx_shift, tx_shift, hold_data, load_data, rx_next;
  logic                      hold_full;
  logic                      sck_rise, sck_fall, cs_fall;
  logic                      rise_en, fall_en, load, abort, byte_done, take_tx;

  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  // Falls are ignored until cs_n has been seen high through a flushed
  // synchronizer, so a select held low across reset never opens a frame.
  assign cs_fall  = armed & cs_prev & ~cs_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rise_en    = 1'b0;
    fall_en    = 1'b0;
    load       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else begin
          rise_en = sck_rise;
          fall_en = sck_fall;
          // A fall with the counter at 0 follows the 8th rise: next byte starts.
          load    = sck_fall && (bit_cnt == '0);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_next   = {rx_shift[SPI_BYTE_W-2:0], mosi_s};
  assign byte_done = rise_en && (bit_cnt == '1);
  assign take_tx   = tx_valid && !hold_full;
  assign load_data = hold_full ? hold_data : (tx_valid ? tx_data : TX_IDLE);
  assign tx_ready  = ~hold_full;
  assign spi_miso  = (state == SHIFT) & tx_shift[SPI_BYTE_W-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      armed     <= 1'b0;
      flush_cnt <= '0;
    end else begin
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      if (flush_cnt != 2'(SYNC_STAGES)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else if (cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      if (abort) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (rise_en) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= rx_next;
      end

      if (load) begin
        tx_shift <= load_data;
      end else if (fall_en) begin
        tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
      end

      // A load with an empty holding register takes tx_data straight through.
      if (load) begin
        hold_full <= 1'b0;
      end else if (take_tx) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      if (byte_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_overrun <= 1'b0;
    end else if (byte_done && rx_valid && !rx_ack) begin
      rx_overrun <= 1'b1;
    end else if (ovr_clr) begin
      rx_overrun <= 1'b0;
    end
  end
`endif

endmodule
